// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared constants and entry type for the fetch-to-decode queue
package if_id_queue_pkg;

  localparam int          INST_W         = 32;
  localparam int          INST_ADDR_W    = 32;
  localparam int          IF_QUEUE_DEPTH = 4;
  localparam logic [31:0] INST_NOP       = 32'h0000_0001;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0]      inst;
    logic [INST_ADDR_W-1:0] addr;
  } if_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - instruction prefetch queue between fetch and decode
// Head entry is presented combinationally; flush drops everything, hold freezes the head.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IF_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INST_W-1:0]            inst_i,
  input  logic [INST_ADDR_W-1:0]       inst_addr_i,
  input  logic                         inst_valid_i,
  output logic                         inst_ready_o,
  input  logic                         hold_flag_i,
  input  logic                         flush_i,
  output logic [INST_W-1:0]            inst_o,
  output logic [INST_ADDR_W-1:0]       inst_addr_o,
  output logic                         inst_valid_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  if_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;

  assign not_empty    = (count_q != '0);
  assign not_full     = (count_q != CNT_FULL);
  assign inst_ready_o = not_full && !flush_i;
  assign push         = inst_valid_i && inst_ready_o;
  assign pop          = not_empty && !hold_flag_i && !flush_i;

  // Flush takes priority over everything and rewinds both pointers to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: occupancy alone decides whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].inst <= inst_i;
      mem_q[wr_ptr_q].addr <= inst_addr_i;
    end
  end

  assign inst_valid_o = not_empty;
  assign inst_o       = not_empty ? mem_q[rd_ptr_q].inst : INST_NOP;
  assign inst_addr_o  = not_empty ? mem_q[rd_ptr_q].addr : ZERO_WORD;
  assign count_o      = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - randomized and directed bench for if_id_queue with a queue-based model
module tb_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic        hold_flag_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [2:0]  count_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] mq[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .hold_flag_i(hold_flag_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain FIFO of {inst, addr}, updated from the interface rules.
  task automatic tick();
    bit do_push;
    bit do_pop;
    if (flush_i) begin
      mq.delete();
    end else begin
      do_push = inst_valid_i && (mq.size() < DEPTH);
      do_pop  = (mq.size() != 0) && !hold_flag_i;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({inst_i, inst_addr_i});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] a,
                       input bit h, input bit f);
    inst_valid_i = v; inst_i = ins; inst_addr_i = a; hold_flag_i = h; flush_i = f;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12 rst = 1'b1;
    @(posedge clk); #1;
    mq.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h13, 32'(i * 4), 1, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0);
    n_total++;
    if (count_o !== 3'd3) $display("FAIL reset_prefill count=%0d exp=3", count_o);
    else n_pass++;
    #2 rst = 1'b0;
    mq.delete();
    #1;
    n_total++;
    if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || inst_o !== 32'h1 || inst_addr_o !== 32'h0)
      $display("FAIL reset_async count=%0d valid=%0b inst=%h addr=%h exp 0/0/00000001/0",
               count_o, inst_valid_o, inst_o, inst_addr_o);
    else n_pass++;
    n_total++;
    if (inst_ready_o !== 1'b1) $display("FAIL reset_ready ready=%0b exp=1", inst_ready_o);
    else n_pass++;
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_hold();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h13, 32'(i * 4), 1, 0);
      tick();
    end
    drive(1, 32'h13, 32'h10, 1, 0);
    n_total++;
    if (count_o !== 3'd4 || inst_ready_o !== 1'b0)
      $display("FAIL fill_full count=%0d ready=%0b exp 4/0", count_o, inst_ready_o);
    else n_pass++;
    tick();
    n_total++;
    if (count_o !== 3'd4 || inst_addr_o !== 32'h0)
      $display("FAIL fill_fifth count=%0d head=%h exp 4/0", count_o, inst_addr_o);
    else n_pass++;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(i * 4) || inst_o !== 32'h13)
        $display("FAIL drain_%0d valid=%0b addr=%h inst=%h exp 1/%h/00000013",
                 i, inst_valid_o, inst_addr_o, inst_o, 32'(i * 4));
      else n_pass++;
      tick();
    end
    n_total++;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'h1 || inst_addr_o !== 32'h0)
      $display("FAIL drain_nop valid=%0b inst=%h addr=%h exp 0/00000001/0",
               inst_valid_o, inst_o, inst_addr_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(i), 32'h40 + 32'(i * 4), 1, 0);
      tick();
    end
    drive(1, 32'hdead, 32'h20, 0, 1);
    #1;
    n_total++;
    if (inst_ready_o !== 1'b0) $display("FAIL flush_ready ready=%0b exp=0", inst_ready_o);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (count_o !== 3'd0 || inst_o !== 32'h1 || inst_valid_o !== 1'b0)
      $display("FAIL flush_empty count=%0d inst=%h valid=%0b exp 0/00000001/0",
               count_o, inst_o, inst_valid_o);
    else n_pass++;
    tick();
    n_total++;
    if (inst_valid_o !== 1'b0 || inst_addr_o === 32'h20)
      $display("FAIL flush_drop valid=%0b addr=%h exp 0/not 20", inst_valid_o, inst_addr_o);
    else n_pass++;
  endtask

  task automatic test_steady();
    logic [31:0] prev;
    drive(1, 32'h200, 32'h80, 0, 0);
    tick();
    prev = 32'h80;
    for (int i = 1; i <= 6; i++) begin
      drive(1, 32'h200 + 32'(i), 32'h80 + 32'(i * 4), 0, 0);
      n_total++;
      if (count_o !== 3'd1 || inst_addr_o !== prev)
        $display("FAIL steady_%0d count=%0d addr=%h exp 1/%h", i, count_o, inst_addr_o, prev);
      else n_pass++;
      prev = 32'h80 + 32'(i * 4);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    int sent = 0;
    int cyc  = 0;
    while ((sent < 10 || inst_valid_o) && cyc < 200) begin
      hold_flag_i = ($urandom_range(0, 2) == 0);
      flush_i = 1'b0;
      inst_valid_i = (sent < 10);
      inst_addr_i = 32'(sent * 4);
      inst_i = 32'h300 + 32'(sent);
      if (inst_valid_o && !hold_flag_i) seen.push_back(inst_addr_o);
      if (inst_valid_i && inst_ready_o) sent++;
      tick();
      cyc++;
    end
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (cyc >= 200) $display("FAIL wrap_timeout cycles=%0d limit=200", cyc);
    else n_pass++;
    n_total++;
    if (seen.size() != 10) $display("FAIL wrap_len got=%0d exp=10", seen.size());
    else n_pass++;
    for (int i = 0; i < seen.size() && i < 10; i++) begin
      n_total++;
      if (seen[i] !== 32'(i * 4))
        $display("FAIL wrap_order_%0d addr=%h exp=%h", i, seen[i], 32'(i * 4));
      else n_pass++;
    end
  endtask

  task automatic test_flush_hold();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h400, 32'h60 + 32'(i * 4), 1, 0);
      tick();
    end
    drive(0, 0, 0, 1, 1);
    n_total++;
    if (count_o !== 3'd2) $display("FAIL fh_pre count=%0d exp=2", count_o);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0);
    n_total++;
    if (count_o !== 3'd0 || inst_valid_o !== 1'b0)
      $display("FAIL fh_flush_wins count=%0d valid=%0b exp 0/0", count_o, inst_valid_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), $urandom(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      #1;
      exp_inst = (mq.size() != 0) ? mq[0][63:32] : 32'h1;
      exp_addr = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
      n_total++;
      if (count_o !== 3'(mq.size()) || inst_valid_o !== (mq.size() != 0) ||
          inst_o !== exp_inst || inst_addr_o !== exp_addr ||
          inst_ready_o !== ((mq.size() != DEPTH) && !flush_i)) begin
        if (errs < 10)
          $display("FAIL random_%0d count=%0d/%0d valid=%0b inst=%h/%h addr=%h/%h ready=%0b",
                   c, count_o, mq.size(), inst_valid_o, inst_o, exp_inst,
                   inst_addr_o, exp_addr, inst_ready_o);
        errs++;
      end else n_pass++;
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill_hold();
    test_flush();
    test_steady();
    test_wrap();
    test_flush_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
